// File: rtl/mem_pkg.sv
// Shared definitions for the data-SRAM responder: access-size encoding,
// the queued request record and the byte-enable / alignment decoder.
package mem_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // Byte-lane enables for an access; returns {be[3:0], misalign}.
   // Misaligned or illegal-size accesses get no lanes so nothing is written.
   function automatic logic [4:0] size_addr_to_be(input logic [1:0] size,
                                                  input logic [1:0] addr_lo);
      logic [3:0] be;
      logic       mis;
      be  = 4'b0000;
      mis = 1'b0;
      case (size)
         MEM_SIZE_BYTE: begin
            be = 4'b0001 << addr_lo;
         end
         MEM_SIZE_HALF: begin
            if (addr_lo[0]) begin
               mis = 1'b1;
            end else if (addr_lo[1]) begin
               be = 4'b1100;
            end else begin
               be = 4'b0011;
            end
         end
         MEM_SIZE_WORD: begin
            if (addr_lo != 2'b00) begin
               mis = 1'b1;
            end else begin
               be = 4'b1111;
            end
         end
         default: begin
            mis = 1'b1;
         end
      endcase
      return {be, mis};
   endfunction

endpackage

// File: rtl/req_fifo.sv
// In-order request queue of QDEPTH entries with full/empty flags.
// Pushes while full and pops while empty are ignored.
module req_fifo
   import mem_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  mem_req_t push_data,
   input  logic     pop,
   output mem_req_t head,
   output logic     full,
   output logic     empty
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = $clog2(QDEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);

   mem_req_t         slot_r [QDEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Flags, qualified push/pop and the head entry.
   always_comb begin
      full      = (count_r == CNT_FULL);
      empty     = (count_r == {CNT_W{1'b0}});
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
      head      = slot_r[rd_ptr_r];
   end

   // Pointer and occupancy bookkeeping; pointers wrap modulo QDEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         slot_r[wr_ptr_r] <= push_data;
      end
   end

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data-SRAM interface: queues requests,
// serves them in order from a byte-writeable word array after LATENCY cycles.
module data_sram_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int QDEPTH      = 2,
   parameter int LATENCY     = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   output logic        misalign_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

   mem_req_t         push_data_s;
   mem_req_t         head_s;
   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             done_s;
   logic [3:0]       be_s;
   logic             mis_s;
   logic [IDX_W-1:0] idx_s;
   logic [CNT_W-1:0] cnt_r;
   logic [31:0]      mem_r [DEPTH_WORDS];
   logic             unused_addr_s;

   req_fifo #(.QDEPTH(QDEPTH)) u_req_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (done_s),
      .head      (head_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   // Upper address bits fold onto the array (addresses wrap).
   assign unused_addr_s = ^head_s.addr[31:IDX_W+2];

   // Acceptance, head decode and completion outputs; all outputs depend on state only.
   always_comb begin
      push_data_s.wr    = data_sram_wr;
      push_data_s.size  = data_sram_size;
      push_data_s.addr  = data_sram_addr;
      push_data_s.wdata = data_sram_wdata;
      push_s            = data_sram_req && !full_s;
      {be_s, mis_s}     = size_addr_to_be(head_s.size, head_s.addr[1:0]);
      idx_s             = head_s.addr[IDX_W+1:2];
      done_s            = !empty_s && (cnt_r == CNT_LAST);
      data_sram_addr_ok = !full_s;
      data_sram_data_ok = done_s;
      data_sram_rdata   = 32'h0000_0000;
      misalign_err      = 1'b0;
      if (done_s) begin
         misalign_err = mis_s;
         if (head_s.wr) begin
            data_sram_rdata = 32'h0000_0000;
         end else begin
            data_sram_rdata = mem_r[idx_s];
         end
      end else begin
         misalign_err    = 1'b0;
         data_sram_rdata = 32'h0000_0000;
      end
   end

   // Service countdown: counts cycles the current head has been visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (done_s || empty_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Array write: enabled lanes commit at the edge ending the completion cycle.
   always_ff @(posedge clk) begin
      if (done_s && head_s.wr && !mis_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem_r[idx_s][8*i +: 8] <= head_s.wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench: one responder with LATENCY=1 and one with LATENCY=4.
module tb_data_sram_responder;

   logic        clk;
   logic        reset;

   logic        req, wr, addr_ok, data_ok, misalign;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata;

   logic        q_req, q_wr, q_addr_ok, q_data_ok, q_misalign;
   logic [1:0]  q_size;
   logic [31:0] q_addr, q_wdata, q_rdata;

   int checks = 0;
   int errors = 0;

   data_sram_responder #(.DEPTH_WORDS(1024), .QDEPTH(2), .LATENCY(1)) u_dut (
      .clk(clk), .reset(reset),
      .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
      .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
      .data_sram_rdata(rdata), .misalign_err(misalign)
   );

   data_sram_responder #(.DEPTH_WORDS(1024), .QDEPTH(2), .LATENCY(4)) u_dut4 (
      .clk(clk), .reset(reset),
      .data_sram_req(q_req), .data_sram_wr(q_wr), .data_sram_size(q_size),
      .data_sram_addr(q_addr), .data_sram_wdata(q_wdata),
      .data_sram_addr_ok(q_addr_ok), .data_sram_data_ok(q_data_ok),
      .data_sram_rdata(q_rdata), .misalign_err(q_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // LATENCY=1 instance: present a request for one cycle (called at negedge).
   task automatic p_issue(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      check("addr_ok", addr_ok, 32'd1);
      req = 1'b1; wr = w; size = s; addr = a; wdata = d;
      @(negedge clk);
   endtask

   task automatic p_done(input string tag, input logic [31:0] exp_rdata, input logic exp_mis);
      check({tag, "_data_ok"}, data_ok, 32'd1);
      check({tag, "_rdata"}, rdata, exp_rdata);
      check({tag, "_misalign"}, misalign, {31'd0, exp_mis});
   endtask

   task automatic p_idle();
      req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
      @(negedge clk);
   endtask

   // LATENCY=4 instance: word read with bounded wait for completion.
   task automatic q_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      int lat;
      check({tag, "_addr_ok"}, q_addr_ok, 32'd1);
      q_req = 1'b1; q_wr = 1'b0; q_size = 2'd2; q_addr = a; q_wdata = 32'd0;
      @(negedge clk);
      q_req = 1'b0;
      lat = 0;
      while (!q_data_ok && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_data_ok"}, q_data_ok, 32'd1);
      check({tag, "_latency"}, lat, 32'd3);
      check({tag, "_rdata"}, q_rdata, exp);
      @(negedge clk);
   endtask

   logic [13:0] exp_aok;
   logic [13:0] exp_dok;
   logic [31:0] seq_data [3];
   int          n;

   initial begin
      req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
      q_req = 1'b0; q_wr = 1'b0; q_size = 2'd0; q_addr = 32'd0; q_wdata = 32'd0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_addr_ok", addr_ok, 32'd1);
      check("rst_data_ok", data_ok, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_misalign", misalign, 32'd0);
      check("rst_q_addr_ok", q_addr_ok, 32'd1);
      check("rst_q_data_ok", q_data_ok, 32'd0);

      // Word write then word read, back to back
      p_issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
      p_done("t1_wr", 32'h0, 1'b0);
      p_issue(1'b0, 2'd2, 32'h10, 32'h0);
      p_done("t1_rd", 32'hDEADBEEF, 1'b0);
      p_idle();
      check("idle_data_ok", data_ok, 32'd0);
      check("idle_rdata", rdata, 32'd0);

      // Byte write into lane 2 over a known word
      p_issue(1'b1, 2'd2, 32'h10, 32'h11223344);
      p_done("t2_wr", 32'h0, 1'b0);
      p_issue(1'b1, 2'd0, 32'h12, 32'h00AB0000);
      p_done("t2_bw", 32'h0, 1'b0);
      p_issue(1'b0, 2'd2, 32'h10, 32'h0);
      p_done("t2_rd", 32'h11AB3344, 1'b0);

      // Misaligned half, misaligned word and illegal size are dropped
      p_issue(1'b1, 2'd1, 32'h13, 32'hFFFFFFFF);
      p_done("t3_half_mis", 32'h0, 1'b1);
      p_issue(1'b1, 2'd2, 32'h12, 32'hFFFFFFFF);
      p_done("t3_word_mis", 32'h0, 1'b1);
      p_issue(1'b1, 2'd3, 32'h10, 32'hFFFFFFFF);
      p_done("t3_size3", 32'h0, 1'b1);
      p_issue(1'b0, 2'd2, 32'h10, 32'h0);
      p_done("t3_rd", 32'h11AB3344, 1'b0);

      // Upper half write and byte write into lane 1
      p_issue(1'b1, 2'd1, 32'h12, 32'h55660000);
      p_done("t4_hw", 32'h0, 1'b0);
      p_issue(1'b1, 2'd0, 32'h11, 32'h00007700);
      p_done("t4_bw", 32'h0, 1'b0);
      p_issue(1'b0, 2'd2, 32'h10, 32'h0);
      p_done("t4_rd", 32'h55667744, 1'b0);

      // Address aliasing modulo the array size
      p_issue(1'b1, 2'd2, 32'h1010, 32'hCAFEF00D);
      p_done("t5_wr", 32'h0, 1'b0);
      p_issue(1'b0, 2'd2, 32'h10, 32'h0);
      p_done("t5_rd", 32'hCAFEF00D, 1'b0);
      p_issue(1'b0, 2'd2, 32'h2010, 32'h0);
      p_done("t5_rd_alias", 32'hCAFEF00D, 1'b0);
      p_idle();

      // LATENCY=4 with req held high: backpressure and spacing of completions
      exp_aok = 14'b11111000100011;
      exp_dok = 14'b01000100010000;
      seq_data[0] = 32'hA0A0A0A0;
      seq_data[1] = 32'hB1B1B1B1;
      seq_data[2] = 32'hC2C2C2C2;
      n = 0;
      for (int c = 0; c < 14; c++) begin
         check($sformatf("t6_addr_ok_c%0d", c), q_addr_ok, {31'd0, exp_aok[c]});
         check($sformatf("t6_data_ok_c%0d", c), q_data_ok, {31'd0, exp_dok[c]});
         if (exp_dok[c]) begin
            check($sformatf("t6_misalign_c%0d", c), q_misalign, 32'd0);
         end
         if (c <= 5) begin
            q_req = 1'b1; q_wr = 1'b1; q_size = 2'd2;
            q_addr = 32'h20 + 32'(4 * n); q_wdata = seq_data[n];
            if (exp_aok[c]) n++;
         end else begin
            q_req = 1'b0;
         end
         @(negedge clk);
      end
      q_read("t6_rd_a", 32'h20, 32'hA0A0A0A0);
      q_read("t6_rd_b", 32'h24, 32'hB1B1B1B1);

      // Reset with two requests queued: they never complete, contents retained
      q_req = 1'b1; q_wr = 1'b0; q_size = 2'd2; q_addr = 32'h20; q_wdata = 32'd0;
      @(negedge clk);
      q_addr = 32'h24;
      @(negedge clk);
      q_req = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t7_q_addr_ok", q_addr_ok, 32'd1);
      check("t7_q_data_ok", q_data_ok, 32'd0);
      check("t7_q_rdata", q_rdata, 32'd0);
      check("t7_addr_ok", addr_ok, 32'd1);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check($sformatf("t7_no_data_ok_c%0d", c), q_data_ok, 32'd0);
      end
      q_read("t7_retain_q", 32'h28, 32'hC2C2C2C2);
      p_issue(1'b0, 2'd2, 32'h10, 32'h0);
      p_done("t7_retain", 32'hCAFEF00D, 1'b0);
      p_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data-SRAM-like interface.
- Accepts read/write requests through an addr_ok/data_ok handshake and queues them in order.
- Services requests against an internal byte-writeable word array after a fixed latency.
- Applies byte enables derived from size and address; returns full 32-bit words for reads. The CPU-side shifters do lane extraction and sign extension.
- Used as the data memory model in core simulation and as the on-chip scratchpad.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- QDEPTH, 2, outstanding-request queue depth; power of two, ≥1.
- LATENCY, 1, cycles from a request reaching queue head to its data_ok; ≥1.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_sram_req  input  1  request valid.
- data_sram_wr  input  1  1 = write, 0 = read.
- data_sram_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- data_sram_addr  input  32  byte address.
- data_sram_wdata  input  32  write data, already lane-positioned by the CPU.
- data_sram_addr_ok  output  1  request accepted this cycle when high together with req.
- data_sram_data_ok  output  1  one-cycle completion pulse, in request order.
- data_sram_rdata  output  32  read word; valid only with data_ok on a read.
- misalign_err  output  1  one-cycle pulse coinciding with data_ok of a misaligned or illegal-size request.

Behaviour:
- Reset (sync, active-high): queue emptied, head countdown cleared.
  - All outputs read 0 in the cycle following the reset edge, except addr_ok, which reads 1.
  - Array contents are not reset.
  - Requests pending at reset are discarded and never receive data_ok.
- Acceptance:
  - addr_ok = !queue_full, a function of state only; no combinational path from req.
  - Accept when req & addr_ok. Push {wr, size, addr, wdata}.
  - While full, addr_ok stays 0 even if the head retires in the same cycle.
- Service:
  - The entry visible at queue head in cycle H (earliest: the cycle after acceptance) asserts data_ok in cycle H+LATENCY-1, then pops.
  - LATENCY=1 with continuous requests gives one data_ok per cycle; in general throughput is one per LATENCY cycles.
- Byte enables from size and addr[1:0]:
  - byte: 1 << addr[1:0].
  - half: 4'b0011 if addr[1]=0, else 4'b1100.
  - word: 4'b1111.
- Misaligned or illegal requests get be = 0; the write is dropped and misalign_err pulses with data_ok. Cases:
  - half with addr[0]=1.
  - word with addr[1:0]≠0.
  - size=3.
- Write: array[index] lanes with be set take wdata lanes, committed at the edge ending the data_ok cycle. rdata = 0.
- Read: rdata = array[index] as seen after all earlier queued writes. Same-cycle write-then-read ordering is preserved because requests are strictly serialized.
- Index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo the array size.
- data_ok, rdata, and misalign_err are 0 whenever no completion occurs.
- Simultaneous push and pop when not full: both happen, and occupancy is unchanged.
- Queue pointers wrap modulo QDEPTH.

Decomposition:
- Shared package `mem_pkg`:
  - size encoding constants (MEM_SIZE_BYTE/HALF/WORD), aligned with the existing memWidth constants.
  - typedef `mem_req_t` {wr, size, addr, wdata}.
  - function `size_addr_to_be(size, addr[1:0])` returning {be[3:0], misalign}.
- One natural sub-module: `req_fifo`, a parameterized QDEPTH synchronous FIFO of mem_req_t with full/empty flags.
- The array and service countdown stay in the top module.

Test Plan:
- Word write 0xDEADBEEF to 0x10, then word read 0x10 (LATENCY=1) -> accepted cycles T, T+1; data_ok at T+1 (write) and T+2 with rdata=0xDEADBEEF.
- Byte write wdata=0x00AB0000 to 0x12 over prior 0x11223344, then read 0x10 -> rdata=0x11AB3344, misalign_err=0.
- Half write to 0x13 -> data_ok with misalign_err=1; subsequent read of 0x10 unchanged.
- QDEPTH=2, LATENCY=4, req held high → addr_ok drops after two accepts, reasserts the cycle after the first data_ok. data_ok appears every 4 cycles, in order.
- Address 0x1000+0x10 with DEPTH_WORDS=1024 -> aliases word 4; reading 0x10 returns the data written.
- Reset asserted with 2 requests queued -> no data_ok afterwards; addr_ok=1 the next cycle; earlier-committed array contents are retained.
